// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer: state encoding,
// one-hot lamp patterns and the default lamp/counter width.
package traffic_pkg;

    localparam int LIGHT_STATE_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_RED     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

endpackage

// File: rtl/traffic_fsm_light_dec.sv
// traffic_light_dec: pure combinational decode of a phase into its lamp pattern
// and light-counter reload. Honours TRAFFIC_FSM_STATE_CHECK_EN for state 11.
module traffic_light_dec
    import traffic_pkg::*;
#(
    parameter int LIGHT_STATE_WIDTH = traffic_pkg::LIGHT_STATE_WIDTH,
    parameter int GREEN_CNT_INIT    = 4,
    parameter int YELLOW_CNT_INIT   = 1,
    parameter int RED_CNT_INIT      = 6
) (
    input  logic [1:0]                   state,
    output logic [LIGHT_STATE_WIDTH-1:0] light,
    output logic [LIGHT_STATE_WIDTH-1:0] cnt_init
);

    always_comb begin
        light    = LIGHT_STATE_WIDTH'(LIGHT_GREEN);
        cnt_init = LIGHT_STATE_WIDTH'(GREEN_CNT_INIT);
        case (state)
            ST_YELLOW: begin
                light    = LIGHT_STATE_WIDTH'(LIGHT_YELLOW);
                cnt_init = LIGHT_STATE_WIDTH'(YELLOW_CNT_INIT);
            end
            ST_RED: begin
                light    = LIGHT_STATE_WIDTH'(LIGHT_RED);
                cnt_init = LIGHT_STATE_WIDTH'(RED_CNT_INIT);
            end
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
            // A corrupted state shows RED so no conflicting direction sees green.
            ST_ILLEGAL: begin
                light    = LIGHT_STATE_WIDTH'(LIGHT_RED);
                cnt_init = LIGHT_STATE_WIDTH'(RED_CNT_INIT);
            end
`endif
            default: begin
                light    = LIGHT_STATE_WIDTH'(LIGHT_GREEN);
                cnt_init = LIGHT_STATE_WIDTH'(GREEN_CNT_INIT);
            end
        endcase
    end

endmodule

// File: rtl/traffic_fsm.sv
// Three-phase traffic-light sequencer (GREEN -> YELLOW -> RED -> GREEN).
// Optional macro TRAFFIC_FSM_STATE_CHECK_EN adds fsm_err and RED fail-safe recovery.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int LIGHT_STATE_WIDTH = traffic_pkg::LIGHT_STATE_WIDTH,
    parameter int GREEN_CNT_INIT    = 4,
    parameter int YELLOW_CNT_INIT   = 1,
    parameter int RED_CNT_INIT      = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         light_cnt_last,
    input  logic                         second_cnt_pre_last,
    output logic [LIGHT_STATE_WIDTH-1:0] light,
    output logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
    ,
    output logic                         fsm_err
`endif
);

    state_t                       state;
    state_t                       next_state;
    logic                         adv;
    logic [LIGHT_STATE_WIDTH-1:0] cur_light;
    logic [LIGHT_STATE_WIDTH-1:0] cur_cnt_unused;
    logic [LIGHT_STATE_WIDTH-1:0] next_light_unused;
    logic [LIGHT_STATE_WIDTH-1:0] next_cnt;

    assign adv = en & light_cnt_last & second_cnt_pre_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // Reset also steers next_state so the reload output reads GREEN while rst is held.
    always_comb begin
        next_state = state;
        if (rst) begin
            next_state = ST_GREEN;
        end else begin
            case (state)
                ST_GREEN:  next_state = adv ? ST_YELLOW : ST_GREEN;
                ST_YELLOW: next_state = adv ? ST_RED    : ST_YELLOW;
                ST_RED:    next_state = adv ? ST_GREEN  : ST_RED;
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
                default:   next_state = ST_RED;
`else
                default:   next_state = ST_GREEN;
`endif
            endcase
        end
    end

    // Lamps come from the state flops; the reload looks ahead at next_state so the
    // external counter can load it on the same edge that enters the phase.
    traffic_light_dec #(
        .LIGHT_STATE_WIDTH(LIGHT_STATE_WIDTH),
        .GREEN_CNT_INIT   (GREEN_CNT_INIT),
        .YELLOW_CNT_INIT  (YELLOW_CNT_INIT),
        .RED_CNT_INIT     (RED_CNT_INIT)
    ) u_dec_cur (
        .state   (state),
        .light   (cur_light),
        .cnt_init(cur_cnt_unused)
    );

    traffic_light_dec #(
        .LIGHT_STATE_WIDTH(LIGHT_STATE_WIDTH),
        .GREEN_CNT_INIT   (GREEN_CNT_INIT),
        .YELLOW_CNT_INIT  (YELLOW_CNT_INIT),
        .RED_CNT_INIT     (RED_CNT_INIT)
    ) u_dec_next (
        .state   (next_state),
        .light   (next_light_unused),
        .cnt_init(next_cnt)
    );

    always_comb begin
        light          = cur_light;
        light_cnt_init = next_cnt;
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
        fsm_err        = (state == ST_ILLEGAL);
`endif
    end

endmodule

// File: tb/tb_traffic_fsm.sv
// Self-checking bench for traffic_fsm: directed steps plus randomized traffic,
// checked against a phase-index model of the light sequence.
module tb_traffic_fsm;

    logic       clk;
    logic       rst;
    logic       en;
    logic       light_cnt_last;
    logic       second_cnt_pre_last;
    logic [2:0] light;
    logic [2:0] light_cnt_init;
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
    logic       fsm_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase index 0=GREEN, 1=YELLOW, 2=RED.
    int phase = 0;
    int reload_tbl[3] = '{4, 1, 6};

    traffic_fsm dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .light_cnt_last     (light_cnt_last),
        .second_cnt_pre_last(second_cnt_pre_last),
        .light              (light),
        .light_cnt_init     (light_cnt_init)
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
        ,
        .fsm_err            (fsm_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] model_lamp(input int p);
        logic [2:0] one = 3'b001;
        return one << p;
    endfunction

    // Drive one cycle of inputs, check lamps and reload before the edge, then
    // advance the model if the edge should step the phase.
    task automatic step(input logic e, input logic l, input logic s, input string tag);
        int exp_reload;
        @(negedge clk);
        en                  = e;
        light_cnt_last      = l;
        second_cnt_pre_last = s;
        #1;
        exp_reload = (e && l && s) ? reload_tbl[(phase + 1) % 3] : reload_tbl[phase];
        check({tag, "_light"}, 32'(light), 32'(model_lamp(phase)));
        check({tag, "_cnt_init"}, 32'(light_cnt_init), 32'(exp_reload));
`ifdef TRAFFIC_FSM_STATE_CHECK_EN
        check({tag, "_fsm_err"}, 32'(fsm_err), 32'd0);
`endif
        @(posedge clk);
        if (e && l && s) phase = (phase + 1) % 3;
    endtask

    initial begin
        // Reset with en=0, held for two cycles.
        rst = 1'b1; en = 1'b0; light_cnt_last = 1'b0; second_cnt_pre_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_light", 32'(light), 32'h1);
        check("reset_cnt_init", 32'(light_cnt_init), 32'd4);
        rst = 1'b0;
        phase = 0;

        step(1'b1, 1'b0, 1'b0, "idle0");
        step(1'b1, 1'b0, 1'b0, "idle1");

        // Single adv pulses walk the full cycle.
        step(1'b1, 1'b1, 1'b1, "g2y");
        step(1'b1, 1'b0, 1'b0, "in_yellow");
        step(1'b1, 1'b1, 1'b1, "y2r");
        step(1'b1, 1'b0, 1'b0, "in_red");
        step(1'b1, 1'b1, 1'b1, "r2g");
        step(1'b1, 1'b0, 1'b0, "in_green");

        // One count input alone never advances.
        repeat (3) step(1'b1, 1'b1, 1'b0, "only_light_last");
        repeat (3) step(1'b1, 1'b0, 1'b1, "only_sec_pre");

        // Disabled FSM ignores both count inputs.
        repeat (3) step(1'b0, 1'b1, 1'b1, "en_low");
        step(1'b1, 1'b1, 1'b1, "en_high_adv");
        step(1'b1, 1'b0, 1'b0, "after_en");

        // Return to GREEN, then hold adv high for three edges.
        while (phase != 0) step(1'b1, 1'b1, 1'b1, "to_green");
        repeat (3) step(1'b1, 1'b1, 1'b1, "adv_hold");
        step(1'b1, 1'b0, 1'b0, "adv_hold_end");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset mid-cycle while in RED, with all inputs active.
        while (phase != 2) step(1'b1, 1'b1, 1'b1, "to_red");
        #2;
        en = 1'b1; light_cnt_last = 1'b1; second_cnt_pre_last = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_light", 32'(light), 32'h1);
        check("async_rst_cnt_init", 32'(light_cnt_init), 32'd4);
        repeat (2) begin
            @(negedge clk);
            check("rst_held_light", 32'(light), 32'h1);
            check("rst_held_cnt_init", 32'(light_cnt_init), 32'd4);
        end
        light_cnt_last = 1'b0; second_cnt_pre_last = 1'b0;
        rst = 1'b0;
        phase = 0;
        step(1'b1, 1'b0, 1'b0, "post_rst");
        step(1'b1, 1'b1, 1'b1, "post_rst_adv");
        step(1'b1, 1'b0, 1'b0, "post_rst_yellow");

`ifdef TRAFFIC_FSM_STATE_CHECK_EN
        // Corrupt the state register: expect a one-cycle error with RED lamps.
        @(negedge clk);
        en = 1'b0; light_cnt_last = 1'b0; second_cnt_pre_last = 1'b0;
        force dut.state = traffic_pkg::state_t'(2'b11);
        #1;
        release dut.state;
        #1;
        check("illegal_fsm_err", 32'(fsm_err), 32'd1);
        check("illegal_light", 32'(light), 32'h4);
        check("illegal_cnt_init", 32'(light_cnt_init), 32'd6);
        @(posedge clk);
        phase = 2;
        step(1'b0, 1'b0, 1'b0, "recovered_red");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
